// File: rtl/spim_resp_slave.sv
// SPI mode-0 responder (MSB first, single lane) for SPI-master bring-up on the FPGA board.
// Pad signals are oversampled in the clk_i domain. Received bytes leave on a valid/ready
// stream, and reply bytes arrive on a second valid/ready stream.
// Optional build macro: SPIM_RESP_SCK_DEGLITCH_EN adds a 3-sample majority filter on the synced
// sck. This adds two cycles of edge latency and suppresses one-cycle sck pulses.
module spim_resp_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       overrun_o,
    output logic       underrun_o,
    output logic       frame_err_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_f;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_rise, sck_fall, csn_rise, csn_fall;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_rx_q, shift_rx_d;
    logic [7:0] shift_tx_q, shift_tx_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic       frame_err_q, frame_err_d;
    logic       tx_load;

    // Pad synchronizers; reset to the idle bus levels so no spurious edge follows reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPIM_RESP_SCK_DEGLITCH_EN
    logic [2:0] sck_hist_q;

    // Keep the last three synced sck samples for the majority vote.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_hist_q <= '0;
        end else begin
            sck_hist_q <= {sck_hist_q[1:0], sck_s};
        end
    end

    assign sck_f = (sck_hist_q[0] & sck_hist_q[1]) | (sck_hist_q[0] & sck_hist_q[2]) |
                   (sck_hist_q[1] & sck_hist_q[2]);
`else
    assign sck_f = sck_s;
`endif

    // Edge-detect flops on the (filtered) sck and the synced csn.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            sck_prev_q <= sck_f;
            csn_prev_q <= csn_s;
        end
    end

    assign sck_rise = sck_f & ~sck_prev_q;
    assign sck_fall = ~sck_f & sck_prev_q;
    assign csn_rise = csn_s & ~csn_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;

    // tx_ready_o is decoded from flops only and must sit in the same cycle as the load edge,
    // so a producer handshake (tx_valid_i & tx_ready_o) matches exactly the byte captured.
    assign tx_ready_o = tx_load;

    // Next-state logic: framing, bit counting, rx holding register and reply loading.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_rx_d  = shift_rx_q;
        shift_tx_d  = shift_tx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_load     = 1'b0;

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d   = StActive;
                    bit_cnt_d = 3'd0;
                    tx_load   = 1'b1;
                end
            end
            StActive: begin
                // csn rising has priority over any sck edge seen in the same cycle.
                if (csn_rise) begin
                    state_d     = StIdle;
                    bit_cnt_d   = 3'd0;
                    shift_rx_d  = 8'h00;
                    frame_err_d = (bit_cnt_q != 3'd0);
                end else if (sck_rise) begin
                    shift_rx_d = {shift_rx_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // A slot frees up if the consumer takes the old byte this very cycle.
                        if (!rx_valid_q || rx_ready_i) begin
                            rx_data_d  = shift_rx_d;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_load = 1'b1;
                    end else begin
                        shift_tx_d = {shift_tx_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (tx_load) begin
            shift_tx_d = tx_valid_i ? tx_data_i : FILL_BYTE;
            underrun_d = ~tx_valid_i;
        end

        oe_d   = (state_d == StActive);
        miso_d = oe_d ? shift_tx_d[7] : 1'b1;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_rx_q  <= 8'h00;
            shift_tx_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_rx_q  <= shift_rx_d;
            shift_tx_q  <= shift_tx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = oe_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign overrun_o     = overrun_q;
    assign underrun_o    = underrun_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spim_resp_slave.sv
// Self-checking bench for spim_resp_slave: directed steps plus randomized frames checked
// against a byte-level model of the SPI transaction.
module tb_spim_resp_slave;

    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck_i, spi_csn_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic       overrun_o, underrun_o, frame_err_o;

    spim_resp_slave #(
        .SYNC_STAGES(2),
        .FILL_BYTE  (FILL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sck_i    (spi_sck_i),
        .spi_csn_i    (spi_csn_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_miso_o   (spi_miso_o),
        .spi_miso_oe_o(spi_miso_oe_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .overrun_o    (overrun_o),
        .underrun_o   (underrun_o),
        .frame_err_o  (frame_err_o)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Running totals kept by the monitor; the main sequence works with deltas.
    int         tot_ovr = 0, tot_und = 0, tot_ferr = 0, tot_txr = 0, tot_rxv = 0;
    logic [7:0] got_q[$];

    initial forever begin
        @(negedge clk);
        if (overrun_o)   tot_ovr++;
        if (underrun_o)  tot_und++;
        if (frame_err_o) tot_ferr++;
        if (tx_ready_o)  tot_txr++;
        if (rx_valid_o)  tot_rxv++;
        if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
    end

    // Reply producer: presents tx_q[0..tx_len-1] in order, advancing on each handshake.
    logic [7:0] tx_q[8];
    int         tx_len = 0, tx_base = 0, tx_pops = 0;

    initial begin
        bit hs;
        int idx;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid_i && tx_ready_o;
            @(posedge clk);
            #1;
            if (hs) tx_pops++;
            idx        = tx_pops - tx_base;
            tx_valid_i = (idx < tx_len);
            tx_data_i  = (idx < tx_len) ? tx_q[idx] : 8'h00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500 us");
        $fatal(1, "bench timeout");
    end

    int s_ovr, s_und, s_ferr, s_txr, s_rxv, s_got;
    logic [7:0] mo_b[8];
    logic [7:0] mi_b[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
            $error("comparison %s did not hold", tag);
        end
    endtask

    task automatic snap();
        s_ovr  = tot_ovr;
        s_und  = tot_und;
        s_ferr = tot_ferr;
        s_txr  = tot_txr;
        s_rxv  = tot_rxv;
        s_got  = got_q.size();
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (s_got + i < got_q.size()) return got_q[s_got + i];
        return 8'hxx;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Half an SPI clock period: sck runs at clk/16.
    task automatic half();
        cyc(8);
    endtask

    // Shift nbits of mo (MSB first); mi collects MISO as the master samples it at sck rise.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit csn_at_end,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = mo[7-i];
            half();
            mi[7-i] = spi_miso_o;
            spi_sck_i = 1'b1;
            half();
            spi_sck_i = 1'b0;
            if (csn_at_end && i == nbits - 1) spi_csn_i = 1'b1;
        end
    endtask

    // One chip-select frame of nbytes from mo_b; csn_at_end raises csn with the last sck fall.
    task automatic run_frame(input int nbytes, input bit csn_at_end);
        logic [7:0] mi;
        spi_csn_i = 1'b0;
        half();
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(mo_b[b], 8, csn_at_end && (b == nbytes - 1), mi);
            mi_b[b] = mi;
        end
        if (!csn_at_end) begin
            half();
            spi_csn_i = 1'b1;
        end
        half();
        half();
    endtask

    initial begin
        logic [7:0] tmp;
        int         n, k, exp_und;

        rst        = 1'b1;
        spi_sck_i  = 1'b0;
        spi_csn_i  = 1'b1;
        spi_mosi_i = 1'b0;
        rx_ready_i = 1'b1;
        cyc(3);

        // Reset values
        check("rst_miso", spi_miso_o, 1);
        check("rst_oe", spi_miso_oe_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_tx_ready", tx_ready_o, 0);
        check("rst_pulses", {overrun_o, underrun_o, frame_err_o}, 0);
        rst = 1'b0;
        cyc(4);

        // Single byte A5, no reply available
        snap();
        mo_b[0] = 8'hA5;
        run_frame(1, 1'b0);
        check("a5_rx_count", got_q.size() - s_got, 1);
        check("a5_rx_data", got_at(0), 8'hA5);
        check("a5_valid_cycles", tot_rxv - s_rxv, 1);
        check("a5_frame_err", tot_ferr - s_ferr, 0);
        check("a5_miso", mi_b[0], FILL);
        check("a5_underruns", tot_und - s_und, 2);

        // Reply 3C then fill; csn rises together with the final sck fall
        tx_q[0] = 8'h3C;
        tx_base = tx_pops;
        tx_len  = 1;
        cyc(2);
        snap();
        mo_b[0] = 8'h81;
        mo_b[1] = 8'h7E;
        run_frame(2, 1'b1);
        tx_len = 0;
        check("reply_byte0", mi_b[0], 8'h3C);
        check("reply_byte1", mi_b[1], FILL);
        check("reply_underruns", tot_und - s_und, 1);
        check("reply_tx_ready", tot_txr - s_txr, 2);
        check("reply_frame_err", tot_ferr - s_ferr, 0);
        check("reply_rx1", got_at(1), 8'h7E);

        // Overrun: consumer stalled across two bytes
        rx_ready_i = 1'b0;
        snap();
        mo_b[0] = 8'h11;
        mo_b[1] = 8'h22;
        run_frame(2, 1'b0);
        check("ovr_valid", rx_valid_o, 1);
        check("ovr_data", rx_data_o, 8'h11);
        check("ovr_pulses", tot_ovr - s_ovr, 1);
        rx_ready_i = 1'b1;
        cyc(1);
        check("ovr_valid_drop", rx_valid_o, 0);
        check("ovr_rx_count", got_q.size() - s_got, 1);
        check("ovr_rx_data", got_at(0), 8'h11);

        // Frame error after 5 bits, then a clean frame
        snap();
        spi_csn_i = 1'b0;
        half();
        spi_bits(8'hF0, 5, 1'b0, tmp);
        half();
        spi_csn_i = 1'b1;
        half();
        half();
        check("ferr_pulses", tot_ferr - s_ferr, 1);
        check("ferr_no_rx", tot_rxv - s_rxv, 0);
        mo_b[0] = 8'h0F;
        run_frame(1, 1'b0);
        check("ferr_next_rx", got_at(0), 8'h0F);
        check("ferr_next_count", tot_ferr - s_ferr, 1);

        // Reset mid-frame
        spi_csn_i = 1'b0;
        half();
        spi_bits(8'hE7, 3, 1'b0, tmp);
        rst = 1'b1;
        #2;
        check("mrst_miso", spi_miso_o, 1);
        check("mrst_oe", spi_miso_oe_o, 0);
        check("mrst_rx_valid", rx_valid_o, 0);
        cyc(3);
        spi_csn_i = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        snap();
        mo_b[0] = 8'h5A;
        run_frame(1, 1'b0);
        check("mrst_rx_data", got_at(0), 8'h5A);
        check("mrst_rx_count", got_q.size() - s_got, 1);
        check("mrst_frame_err", tot_ferr - s_ferr, 0);

        // Randomized frames: n bytes out, k reply bytes queued
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(3, 1);
            k = $urandom_range(4, 0);
            for (int i = 0; i < 8; i++) begin
                tx_q[i] = 8'($urandom);
                mo_b[i] = 8'($urandom);
            end
            tx_base = tx_pops;
            tx_len  = k;
            cyc(2);
            snap();
            run_frame(n, 1'b0);
            tx_len = 0;
            // A frame of n bytes loads n+1 reply bytes: at csn fall and after every byte.
            exp_und = (n + 1 > k) ? (n + 1 - k) : 0;
            for (int i = 0; i < n; i++) begin
                check($sformatf("rnd%0d_miso%0d", f, i), mi_b[i], (i < k) ? tx_q[i] : FILL);
                check($sformatf("rnd%0d_rx%0d", f, i), got_at(i), mo_b[i]);
            end
            check($sformatf("rnd%0d_underruns", f), tot_und - s_und, exp_und);
            check($sformatf("rnd%0d_tx_ready", f), tot_txr - s_txr, n + 1);
            check($sformatf("rnd%0d_overruns", f), tot_ovr - s_ovr, 0);
        end

`ifdef SPIM_RESP_SCK_DEGLITCH_EN
        // One-cycle sck glitch in the low phase before bit 4
        snap();
        spi_csn_i = 1'b0;
        half();
        tmp = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            spi_mosi_i = tmp[7-i];
            if (i == 4) begin
                cyc(3);
                spi_sck_i = 1'b1;
                cyc(1);
                spi_sck_i = 1'b0;
                cyc(4);
            end else begin
                half();
            end
            spi_sck_i = 1'b1;
            half();
            spi_sck_i = 1'b0;
        end
        half();
        spi_csn_i = 1'b1;
        half();
        half();
        check("glitch_rx_data", got_at(0), 8'hC3);
        check("glitch_rx_count", got_q.size() - s_got, 1);
        check("glitch_frame_err", tot_ferr - s_ferr, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
